// File: rtl/ray_block_scene_traverser.sv
// Sequences one ray against every scene block through the intersection unit
// and reduces the returned (hit, t) stream to the nearest non-negative hit.
module ray_block_scene_traverser #(
    parameter int NUM_BLOCKS = 4,
    parameter int IDX_W      = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [31:0]      ray_x,
    input  logic [31:0]      ray_y,
    input  logic [31:0]      ray_z,
    input  logic             ray_valid,
    output logic             ray_ready,
    output logic [IDX_W-1:0] block_addr,
    input  logic [31:0]      block_pos_x,
    input  logic [31:0]      block_pos_y,
    input  logic [31:0]      block_pos_z,
    output logic [31:0]      isect_ray_x,
    output logic [31:0]      isect_ray_y,
    output logic [31:0]      isect_ray_z,
    output logic [31:0]      isect_block_x,
    output logic [31:0]      isect_block_y,
    output logic [31:0]      isect_block_z,
    output logic             isect_valid,
    input  logic             res_hit,
    input  logic [31:0]      res_t,
    input  logic             res_valid,
    output logic             hit_out,
    output logic [IDX_W-1:0] hit_idx,
    output logic [31:0]      hit_t,
    output logic             result_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(NUM_BLOCKS - 1);
    localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [31:0]      ray_x_r;
    logic [31:0]      ray_y_r;
    logic [31:0]      ray_z_r;
    logic [IDX_W:0]   issue_cnt_r;
    logic [IDX_W:0]   ret_cnt_r;
    logic             best_valid_r;
    logic [31:0]      best_t_r;
    logic [IDX_W-1:0] best_idx_r;
    logic             isect_valid_r;
    logic             result_valid_r;
    logic             hit_out_r;
    logic [IDX_W-1:0] hit_idx_r;
    logic [31:0]      hit_t_r;

    logic             accept_s;
    logic             ret_s;
    logic             last_ret_s;
    logic             issue_last_s;
    logic             cand_s;
    logic             nxt_best_valid_s;
    logic [31:0]      nxt_best_t_s;
    logic [IDX_W-1:0] nxt_best_idx_s;

    // A hit behind the ray origin (sign bit set) never qualifies; +0.0 does.
    function automatic logic is_candidate(input logic hit, input logic [31:0] t);
        return hit & ~t[31];
    endfunction

    assign ray_ready    = (state_r == IDLE) & ~rst_in;
    assign accept_s     = ray_valid & ray_ready;
    assign ret_s        = res_valid & ((state_r == ISSUE) | (state_r == DRAIN));
    assign last_ret_s   = ret_s & (ret_cnt_r == LAST_CNT);
    assign issue_last_s = (state_r == ISSUE) & (issue_cnt_r == LAST_CNT);

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = ISSUE;
                else          state_nxt_s = IDLE;
            end
            ISSUE: begin
                if (issue_last_s) state_nxt_s = DRAIN;
                else              state_nxt_s = ISSUE;
            end
            DRAIN: begin
                if (last_ret_s) state_nxt_s = DONE;
                else            state_nxt_s = DRAIN;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Nearest-hit merge; strict less-than keeps the earlier index on ties
    always_comb begin
        nxt_best_valid_s = best_valid_r;
        nxt_best_t_s     = best_t_r;
        nxt_best_idx_s   = best_idx_r;
        cand_s           = ret_s & is_candidate(res_hit, res_t);
        if (cand_s && (!best_valid_r || (res_t < best_t_r))) begin
            nxt_best_valid_s = 1'b1;
            nxt_best_t_s     = res_t;
            nxt_best_idx_s   = ret_cnt_r[IDX_W-1:0];
        end else begin
            nxt_best_valid_s = best_valid_r;
            nxt_best_t_s     = best_t_r;
            nxt_best_idx_s   = best_idx_r;
        end
    end

    // Ray latch, issue/return counters and running best
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ray_x_r      <= 32'd0;
            ray_y_r      <= 32'd0;
            ray_z_r      <= 32'd0;
            issue_cnt_r  <= '0;
            ret_cnt_r    <= '0;
            best_valid_r <= 1'b0;
            best_t_r     <= 32'd0;
            best_idx_r   <= '0;
        end else if (accept_s) begin
            ray_x_r      <= ray_x;
            ray_y_r      <= ray_y;
            ray_z_r      <= ray_z;
            issue_cnt_r  <= '0;
            ret_cnt_r    <= '0;
            best_valid_r <= 1'b0;
            best_t_r     <= 32'd0;
            best_idx_r   <= '0;
        end else begin
            // Address holds on the last block so block_addr never wraps
            if (state_r == ISSUE && !issue_last_s) begin
                issue_cnt_r <= issue_cnt_r + CNT_ONE;
            end
            if (ret_s) begin
                ret_cnt_r    <= ret_cnt_r + CNT_ONE;
                best_valid_r <= nxt_best_valid_s;
                best_t_r     <= nxt_best_t_s;
                best_idx_r   <= nxt_best_idx_s;
            end
        end
    end

    // Issue strobe and final result registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            isect_valid_r  <= 1'b0;
            result_valid_r <= 1'b0;
            hit_out_r      <= 1'b0;
            hit_idx_r      <= '0;
            hit_t_r        <= 32'd0;
        end else begin
            isect_valid_r  <= (state_r == ISSUE);
            result_valid_r <= last_ret_s;
            if (last_ret_s) begin
                hit_out_r <= nxt_best_valid_s;
                hit_idx_r <= nxt_best_valid_s ? nxt_best_idx_s : '0;
                hit_t_r   <= nxt_best_valid_s ? nxt_best_t_s : 32'd0;
            end
        end
    end

    assign block_addr    = issue_cnt_r[IDX_W-1:0];
    assign isect_valid   = isect_valid_r;
    // Memory data arrives the cycle after its address, aligned with the strobe
    assign isect_ray_x   = isect_valid_r ? ray_x_r : 32'd0;
    assign isect_ray_y   = isect_valid_r ? ray_y_r : 32'd0;
    assign isect_ray_z   = isect_valid_r ? ray_z_r : 32'd0;
    assign isect_block_x = isect_valid_r ? block_pos_x : 32'd0;
    assign isect_block_y = isect_valid_r ? block_pos_y : 32'd0;
    assign isect_block_z = isect_valid_r ? block_pos_z : 32'd0;
    assign hit_out       = hit_out_r;
    assign hit_idx       = hit_idx_r;
    assign hit_t         = hit_t_r;
    assign result_valid  = result_valid_r;

endmodule

// File: tb/tb_ray_block_scene_traverser.sv
// Directed bench: block memory and a 5-cycle intersection model are stepped
// from the bench tasks; expected results are hand-computed per scenario.
module tb_ray_block_scene_traverser;

    localparam int NUM_BLOCKS = 4;
    localparam int IDX_W      = 8;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [31:0]      ray_x, ray_y, ray_z;
    logic             ray_valid;
    logic             ray_ready;
    logic [IDX_W-1:0] block_addr;
    logic [31:0]      block_pos_x, block_pos_y, block_pos_z;
    logic [31:0]      isect_ray_x, isect_ray_y, isect_ray_z;
    logic [31:0]      isect_block_x, isect_block_y, isect_block_z;
    logic             isect_valid;
    logic             res_hit;
    logic [31:0]      res_t;
    logic             res_valid;
    logic             hit_out;
    logic [IDX_W-1:0] hit_idx;
    logic [31:0]      hit_t;
    logic             result_valid;

    int errors = 0;
    int checks = 0;

    logic [31:0]      mem_x [4];
    logic [31:0]      mem_y [4];
    logic [31:0]      mem_z [4];
    logic             hit_tab [4];
    logic [31:0]      t_tab [4];
    logic             pv [5];
    int               pidx [5];
    int               issue_ctr;
    logic [IDX_W-1:0] prev_addr;
    logic             prev_iv;

    ray_block_scene_traverser #(.NUM_BLOCKS(NUM_BLOCKS), .IDX_W(IDX_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .ray_x(ray_x), .ray_y(ray_y), .ray_z(ray_z),
        .ray_valid(ray_valid), .ray_ready(ray_ready),
        .block_addr(block_addr),
        .block_pos_x(block_pos_x), .block_pos_y(block_pos_y), .block_pos_z(block_pos_z),
        .isect_ray_x(isect_ray_x), .isect_ray_y(isect_ray_y), .isect_ray_z(isect_ray_z),
        .isect_block_x(isect_block_x), .isect_block_y(isect_block_y),
        .isect_block_z(isect_block_z), .isect_valid(isect_valid),
        .res_hit(res_hit), .res_t(res_t), .res_valid(res_valid),
        .hit_out(hit_out), .hit_idx(hit_idx), .hit_t(hit_t),
        .result_valid(result_valid)
    );

    always #5 clk_in = ~clk_in;

    // One clock: after the edge, update memory read data and the latency-5 model,
    // then sample registered DUT outputs for the next step.
    task automatic tick();
        @(posedge clk_in);
        #1;
        block_pos_x = mem_x[int'(prev_addr) % 4];
        block_pos_y = mem_y[int'(prev_addr) % 4];
        block_pos_z = mem_z[int'(prev_addr) % 4];
        for (int i = 4; i > 0; i--) begin
            pv[i]   = pv[i-1];
            pidx[i] = pidx[i-1];
        end
        pv[0]   = prev_iv;
        pidx[0] = issue_ctr;
        if (prev_iv) issue_ctr++;
        if (pv[4]) begin
            res_valid = 1'b1;
            res_hit   = hit_tab[pidx[4] % 4];
            res_t     = t_tab[pidx[4] % 4];
        end else begin
            res_valid = 1'b0;
            res_hit   = 1'b0;
            res_t     = 32'd0;
        end
        #1;
        prev_addr = block_addr;
        prev_iv   = isect_valid;
    endtask

    task automatic set_tab(input logic [3:0] h, input logic [31:0] t0, input logic [31:0] t1,
                           input logic [31:0] t2, input logic [31:0] t3);
        for (int i = 0; i < 4; i++) hit_tab[i] = h[i];
        t_tab[0] = t0; t_tab[1] = t1; t_tab[2] = t2; t_tab[3] = t3;
    endtask

    // Full ray from handshake (cycle 0) to cycle 14 with timing and data checks.
    task automatic run_ray(input string name, input logic [31:0] rx, input logic [31:0] ry,
                           input logic [31:0] rz, input logic hold,
                           input logic exp_hit, input logic [IDX_W-1:0] exp_idx,
                           input logic [31:0] exp_t);
        int               rv_cnt;
        int               rv_cyc;
        logic             got_hit;
        logic [IDX_W-1:0] got_idx;
        logic [31:0]      got_t;
        logic             exp_ready;
        logic             exp_iv;
        rv_cnt = 0; rv_cyc = -1; got_hit = 1'b0; got_idx = '0; got_t = 32'd0;
        checks++;
        if (ray_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_start got=%b exp=1", name, ray_ready);
        end
        ray_x = rx; ray_y = ry; ray_z = rz; ray_valid = 1'b1;
        issue_ctr = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) begin
                ray_x = 32'hDEAD_BEEF; ray_y = 32'hCAFE_F00D; ray_z = 32'h1234_5678;
                ray_valid = hold;
            end
            if (c == 11) ray_valid = 1'b0;
            exp_ready = (c >= 12);
            checks++;
            if (ray_ready !== exp_ready) begin
                errors++;
                $display("FAIL %s ray_ready cyc=%0d got=%b exp=%b", name, c, ray_ready, exp_ready);
            end
            if (c <= 4) begin
                checks++;
                if (block_addr !== IDX_W'(c - 1)) begin
                    errors++;
                    $display("FAIL %s block_addr cyc=%0d got=%0d exp=%0d", name, c, block_addr, c - 1);
                end
            end
            exp_iv = (c >= 2) && (c <= 5);
            checks++;
            if (isect_valid !== exp_iv) begin
                errors++;
                $display("FAIL %s isect_valid cyc=%0d got=%b exp=%b", name, c, isect_valid, exp_iv);
            end
            if (exp_iv) begin
                checks++;
                if ({isect_block_x, isect_block_y, isect_block_z} !==
                    {mem_x[c-2], mem_y[c-2], mem_z[c-2]}) begin
                    errors++;
                    $display("FAIL %s isect_block cyc=%0d got=%h %h %h exp=%h %h %h", name, c,
                             isect_block_x, isect_block_y, isect_block_z,
                             mem_x[c-2], mem_y[c-2], mem_z[c-2]);
                end
                checks++;
                if ({isect_ray_x, isect_ray_y, isect_ray_z} !== {rx, ry, rz}) begin
                    errors++;
                    $display("FAIL %s isect_ray cyc=%0d got=%h %h %h exp=%h %h %h", name, c,
                             isect_ray_x, isect_ray_y, isect_ray_z, rx, ry, rz);
                end
            end
            if (result_valid === 1'b1) begin
                rv_cnt++;
                rv_cyc  = c;
                got_hit = hit_out; got_idx = hit_idx; got_t = hit_t;
            end
        end
        checks++;
        if (rv_cnt != 1 || rv_cyc != 11) begin
            errors++;
            $display("FAIL %s result_valid count=%0d cyc=%0d exp count=1 cyc=11", name, rv_cnt, rv_cyc);
        end
        checks++;
        if ({got_hit, got_idx, got_t} !== {exp_hit, exp_idx, exp_t}) begin
            errors++;
            $display("FAIL %s result got hit=%b idx=%0d t=%h exp hit=%b idx=%0d t=%h", name,
                     got_hit, got_idx, got_t, exp_hit, exp_idx, exp_t);
        end
        checks++;
        if ({hit_out, hit_idx, hit_t} !== {exp_hit, exp_idx, exp_t}) begin
            errors++;
            $display("FAIL %s result_hold got hit=%b idx=%0d t=%h exp hit=%b idx=%0d t=%h", name,
                     hit_out, hit_idx, hit_t, exp_hit, exp_idx, exp_t);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        checks++;
        if (ray_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset ray_ready got=%b exp=0", ray_ready);
        end
        checks++;
        if ({isect_valid, result_valid, hit_out, hit_idx, hit_t, block_addr} !== '0) begin
            errors++;
            $display("FAIL reset ctrl got iv=%b rv=%b hit=%b idx=%0d t=%h addr=%0d exp all 0",
                     isect_valid, result_valid, hit_out, hit_idx, hit_t, block_addr);
        end
        checks++;
        if ({isect_ray_x, isect_ray_y, isect_ray_z, isect_block_x, isect_block_y, isect_block_z} !== '0) begin
            errors++;
            $display("FAIL reset isect_data got nonzero exp 0");
        end
        rst_in = 1'b0;
        tick();
        checks++;
        if (ray_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ray_ready got=%b exp=1", ray_ready);
        end
    endtask

    task automatic test_nearest();
        set_tab(4'b1111, 32'h40A0_0000, 32'h4000_0000, 32'h40E0_0000, 32'h4040_0000);
        run_ray("nearest", 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 1'b0,
                1'b1, 8'd1, 32'h4000_0000);
    endtask

    task automatic test_hold_valid();
        set_tab(4'b1111, 32'h40A0_0000, 32'h4000_0000, 32'h40E0_0000, 32'h4040_0000);
        run_ray("hold_valid", 32'h3E80_0000, 32'h3F00_0000, 32'h3F40_0000, 1'b1,
                1'b1, 8'd1, 32'h4000_0000);
    endtask

    task automatic test_all_miss();
        set_tab(4'b0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        run_ray("all_miss", 32'h4110_0000, 32'h0000_0000, 32'h3F80_0000, 1'b0,
                1'b0, 8'd0, 32'd0);
    endtask

    task automatic test_ties();
        set_tab(4'b1100, 32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, 32'h4080_0000);
        run_ray("ties", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0,
                1'b1, 8'd2, 32'h4080_0000);
    endtask

    task automatic test_negative();
        set_tab(4'b1001, 32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4110_0000);
        run_ray("negative_t", 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0,
                1'b1, 8'd3, 32'h4110_0000);
    endtask

    task automatic test_plus_zero();
        set_tab(4'b1111, 32'hBF80_0000, 32'h0000_0000, 32'h4000_0000, 32'h4110_0000);
        run_ray("plus_zero", 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 1'b0,
                1'b1, 8'd1, 32'h0000_0000);
    endtask

    task automatic test_reset_drain();
        set_tab(4'b1111, 32'h40A0_0000, 32'h4000_0000, 32'h40E0_0000, 32'h4040_0000);
        ray_x = 32'h3F80_0000; ray_y = 32'h3F80_0000; ray_z = 32'h3F80_0000;
        ray_valid = 1'b1;
        issue_ctr = 0;
        tick();
        ray_valid = 1'b0;
        repeat (6) tick();
        rst_in = 1'b1;
        #1;
        checks++;
        if (ray_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain ray_ready got=%b exp=0", ray_ready);
        end
        checks++;
        if ({isect_valid, result_valid, hit_out, hit_idx, hit_t, block_addr} !== '0) begin
            errors++;
            $display("FAIL reset_drain clear got iv=%b rv=%b hit=%b idx=%0d t=%h addr=%0d exp all 0",
                     isect_valid, result_valid, hit_out, hit_idx, hit_t, block_addr);
        end
        tick();
        rst_in = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (result_valid !== 1'b0 || ray_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_drain stale step=%0d got rv=%b ready=%b exp rv=0 ready=1",
                         c, result_valid, ray_ready);
            end
        end
        run_ray("after_reset", 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 1'b0,
                1'b1, 8'd1, 32'h4000_0000);
    endtask

    initial begin
        rst_in = 1'b1;
        ray_x = 32'd0; ray_y = 32'd0; ray_z = 32'd0; ray_valid = 1'b0;
        block_pos_x = 32'd0; block_pos_y = 32'd0; block_pos_z = 32'd0;
        res_hit = 1'b0; res_t = 32'd0; res_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pv[i] = 1'b0;
            pidx[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            mem_x[i] = 32'h1000_0000 + 32'(i);
            mem_y[i] = 32'h2000_0010 + 32'(i * 3);
            mem_z[i] = 32'h3000_0100 + 32'(i * 7);
        end
        issue_ctr = 0;
        prev_addr = '0;
        prev_iv = 1'b0;
        set_tab(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);

        test_reset();
        test_nearest();
        test_hold_valid();
        test_all_miss();
        test_ties();
        test_negative();
        test_plus_zero();
        test_reset_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
